// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment reader: segment code table,
// blank pattern, default digit count and the frame FSM states.
package seg7_pkg;

  localparam int DIGITS_DEF = 4;

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  // Active-low patterns, bit order g,f,e,d,c,b,a; entry index is the nibble value.
  localparam logic [6:0] SEG_CODES [16] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
    7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
    7'b000_0000, 7'b001_0000, 7'b000_1000, 7'b000_0011,
    7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110
  };

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to hex nibble decoder; any pattern
// outside the code table (blank included) yields nibble 0 with bad set.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       bad
);

  always_comb begin
    nibble = 4'h0;
    bad    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_CODES[i]) begin
        nibble = 4'(i);
        bad    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Samples a multiplexed seven-segment display bus, debounces each digit
// select, assembles complete frames and hands them out with valid/ready.
module seven_segment_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   out_digits,
  output logic [DIGITS-1:0]     out_bad,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam int         IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  logic [DIGITS+6:0]         prev_q, prev_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [DIGITS-1:0]         mask_q, mask_d;
  logic [DIGITS-1:0][3:0]    slot_nib_q, slot_nib_d;
  logic [DIGITS-1:0]         slot_bad_q, slot_bad_d;
  logic [4*DIGITS-1:0]       dig_q, dig_d;
  logic [DIGITS-1:0]         bad_q, bad_d;
  logic                      ovr_q, ovr_d;
  state_e                    state_q, state_d;

  logic [3:0]                dec_nib;
  logic                      dec_bad;
  logic                      sel_ok;
  logic [IDX_W-1:0]          sel_idx;
  logic                      capture;
  logic                      frame_done;

  seg7_decode u_decode (
    .seg    (seg_in),
    .nibble (dec_nib),
    .bad    (dec_bad)
  );

  always_comb begin
    sel_ok  = $onehot(~an_in);
    sel_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_in[i]) sel_idx = IDX_W'(i);
    end

    // Counter saturates at STABLE_CYCLES so a held digit captures only once.
    prev_d = {an_in, seg_in};
    if (!sel_ok) begin
      cnt_d = 8'd0;
    end else if ((prev_d == prev_q) && (cnt_q != 8'd0)) begin
      cnt_d = (cnt_q == STABLE_C) ? cnt_q : cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd1;
    end
    capture    = sel_ok && (cnt_d == STABLE_C) && (cnt_q != STABLE_C);
    frame_done = &mask_q;

    mask_d     = frame_done ? '0 : mask_q;
    slot_nib_d = slot_nib_q;
    slot_bad_d = slot_bad_q;
    if (capture) begin
      slot_nib_d[sel_idx] = dec_nib;
      slot_bad_d[sel_idx] = dec_bad;
      mask_d[sel_idx]     = 1'b1;
    end

    state_d = state_q;
    dig_d   = dig_q;
    bad_d   = bad_q;
    ovr_d   = ovr_q;
    case (state_q)
      COLLECT: begin
        if (frame_done) begin
          dig_d   = slot_nib_q;
          bad_d   = slot_bad_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // A frame finishing while the held one is still unaccepted is dropped.
        if (frame_done && out_ready) begin
          dig_d = slot_nib_q;
          bad_d = slot_bad_q;
        end else if (frame_done) begin
          ovr_d = 1'b1;
        end else if (out_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q     <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      slot_nib_q <= '0;
      slot_bad_q <= '0;
      dig_q      <= '0;
      bad_q      <= '0;
      ovr_q      <= 1'b0;
      state_q    <= COLLECT;
    end else begin
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      slot_nib_q <= slot_nib_d;
      slot_bad_q <= slot_bad_d;
      dig_q      <= dig_d;
      bad_q      <= bad_d;
      ovr_q      <= ovr_d;
      state_q    <= state_d;
    end
  end

  assign out_digits = dig_q;
  assign out_bad    = bad_q;
  assign out_valid  = (state_q == HOLD);
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader: table-driven frame vectors plus
// hand-written sequences for debounce, invalid select, overrun and reset.
module tb_seven_segment_reader;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] out_digits;
  logic [3:0]  out_bad;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  int          checks;
  int          failures;
  int          vcnt;
  logic [15:0] last_d;
  logic [3:0]  last_b;

  typedef struct {
    logic [3:0][6:0] seg;
    logic [15:0]     exp_d;
    logic [3:0]      exp_b;
  } vec_t;

  vec_t vecs [5];

  seven_segment_reader #(.STABLE_CYCLES(4), .DIGITS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .an_in      (an_in),
    .out_digits (out_digits),
    .out_bad    (out_bad),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] code(input logic [3:0] n);
    case (n)
      4'h0: code = 7'b1000000;
      4'h1: code = 7'b1111001;
      4'h2: code = 7'b0100100;
      4'h3: code = 7'b0110000;
      4'h4: code = 7'b0011001;
      4'h5: code = 7'b0010010;
      4'h6: code = 7'b0000010;
      4'h7: code = 7'b1111000;
      4'h8: code = 7'b0000000;
      4'h9: code = 7'b0010000;
      4'hA: code = 7'b0001000;
      4'hB: code = 7'b0000011;
      4'hC: code = 7'b1000110;
      4'hD: code = 7'b0100001;
      4'hE: code = 7'b0000110;
      default: code = 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive inputs for one cycle, then sample outputs at the falling edge.
  task automatic cyc(input logic [3:0] an, input logic [6:0] seg, input logic rdy);
    an_in     = an;
    seg_in    = seg;
    out_ready = rdy;
    @(negedge clk);
    if (out_valid) begin
      vcnt++;
      last_d = out_digits;
      last_b = out_bad;
    end
  endtask

  task automatic scan(input int d, input logic [6:0] seg, input int n, input logic rdy);
    logic [3:0] an;
    an = ~(4'b0001 << d);
    for (int k = 0; k < n; k++) cyc(an, seg, rdy);
  endtask

  task automatic blank(input int n, input logic rdy);
    for (int k = 0; k < n; k++) cyc(4'hF, 7'h7F, rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    blank(2, 1'b1);
    rst_n = 1'b1;
    vcnt  = 0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    vcnt      = 0;
    last_d    = '0;
    last_b    = '0;
    rst_n     = 1'b0;
    an_in     = 4'hF;
    seg_in    = 7'h7F;
    out_ready = 1'b1;

    vecs[0].seg = {code(4'h4), code(4'h3), code(4'h2), code(4'h1)};
    vecs[0].exp_d = 16'h4321; vecs[0].exp_b = 4'b0000;
    vecs[1].seg = {code(4'hD), code(4'hC), code(4'hB), code(4'hA)};
    vecs[1].exp_d = 16'hDCBA; vecs[1].exp_b = 4'b0000;
    vecs[2].seg = {code(4'h0), code(4'h8), code(4'hF), code(4'hE)};
    vecs[2].exp_d = 16'h08FE; vecs[2].exp_b = 4'b0000;
    vecs[3].seg = {code(4'h7), code(4'h6), 7'b1111111, code(4'h5)};
    vecs[3].exp_d = 16'h7605; vecs[3].exp_b = 4'b0010;
    vecs[4].seg = {code(4'h9), 7'b0101010, code(4'h9), code(4'h9)};
    vecs[4].exp_d = 16'h9099; vecs[4].exp_b = 4'b0100;

    do_reset();
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_digits", 32'(out_digits), 32'h0);
    chk("reset_bad", 32'(out_bad), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'd0);

    // Full frames, each digit held 6 cycles with the consumer always ready.
    for (int v = 0; v < 5; v++) begin
      vcnt = 0;
      for (int d = 0; d < 4; d++) scan(d, vecs[v].seg[d], 6, 1'b1);
      blank(4, 1'b1);
      chk($sformatf("vec%0d_pulses", v), 32'(vcnt), 32'd1);
      chk($sformatf("vec%0d_digits", v), 32'(last_d), 32'(vecs[v].exp_d));
      chk($sformatf("vec%0d_bad", v), 32'(last_b), 32'(vecs[v].exp_b));
    end

    // Digit 2 held too briefly: frame must wait for its rescan.
    do_reset();
    scan(0, code(4'h1), 6, 1'b1);
    scan(1, code(4'h2), 6, 1'b1);
    scan(2, code(4'h3), 3, 1'b1);
    scan(3, code(4'h4), 6, 1'b1);
    blank(3, 1'b1);
    chk("short_no_valid", 32'(vcnt), 32'd0);
    scan(2, code(4'h3), 4, 1'b1);
    blank(3, 1'b1);
    chk("short_rescan_pulses", 32'(vcnt), 32'd1);
    chk("short_rescan_digits", 32'(last_d), 32'h4321);

    // Multi-select must capture nothing and leave the mask alone.
    do_reset();
    scan(0, code(4'h5), 6, 1'b1);
    scan(1, code(4'h6), 6, 1'b1);
    scan(2, code(4'h7), 6, 1'b1);
    for (int k = 0; k < 10; k++) cyc(4'b0011, code(4'h9), 1'b1);
    blank(3, 1'b1);
    chk("multisel_no_valid", 32'(vcnt), 32'd0);
    scan(3, code(4'h8), 6, 1'b1);
    blank(3, 1'b1);
    chk("multisel_pulses", 32'(vcnt), 32'd1);
    chk("multisel_digits", 32'(last_d), 32'h8765);

    // Consumer stalled across two frames: first held, second dropped.
    do_reset();
    for (int d = 0; d < 4; d++) scan(d, code(4'(d + 1)), 6, 1'b0);
    blank(2, 1'b0);
    chk("stall_valid_a", 32'(out_valid), 32'd1);
    chk("stall_digits_a", 32'(out_digits), 32'h4321);
    chk("stall_overrun_a", 32'(overrun), 32'd0);
    for (int d = 0; d < 4; d++) scan(d, code(4'(d + 5)), 6, 1'b0);
    blank(3, 1'b0);
    chk("stall_valid_b", 32'(out_valid), 32'd1);
    chk("stall_digits_b", 32'(out_digits), 32'h4321);
    chk("stall_overrun_b", 32'(overrun), 32'd1);
    blank(1, 1'b1);
    chk("accept_valid_drop", 32'(out_valid), 32'd0);
    chk("accept_overrun_sticky", 32'(overrun), 32'd1);

    // Reset after a held frame and three partial captures discards everything.
    do_reset();
    for (int d = 0; d < 4; d++) scan(d, code(4'(d + 5)), 6, 1'b0);
    scan(0, code(4'h9), 6, 1'b0);
    scan(1, code(4'h8), 6, 1'b0);
    scan(2, code(4'h7), 6, 1'b0);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    blank(1, 1'b0);
    rst_n = 1'b1;
    chk("midreset_valid", 32'(out_valid), 32'd0);
    chk("midreset_digits", 32'(out_digits), 32'h0);
    chk("midreset_bad", 32'(out_bad), 32'h0);
    chk("midreset_overrun", 32'(overrun), 32'd0);
    vcnt = 0;
    scan(3, code(4'hA), 6, 1'b1);
    blank(3, 1'b1);
    chk("postreset_partial", 32'(vcnt), 32'd0);
    scan(0, code(4'h1), 6, 1'b1);
    scan(1, code(4'h2), 6, 1'b1);
    scan(2, code(4'h3), 6, 1'b1);
    blank(3, 1'b1);
    chk("postreset_pulses", 32'(vcnt), 32'd1);
    chk("postreset_digits", 32'(last_d), 32'hA321);
    chk("postreset_bad", 32'(last_b), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segment_reader.md
SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive identical cycles required before a digit is captured (legal range 2..255).
REQ-002 Parameter DIGITS, default 4, SHALL set the number of multiplexed digits per frame; only 4 is required to be supported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset; synchronous, active-low.
REQ-005 seg_in  input  7  SHALL carry the active-low segment pattern, bit order g,f,e,d,c,b,a (bit6..bit0).
REQ-006 an_in  input  4  SHALL carry the active-low digit select; an_in[i]=0 selects digit i.
REQ-007 out_digits  output  16  SHALL carry the decoded frame; digit i in bits [4i+3:4i].
REQ-008 out_bad  output  4  SHALL flag digits whose captured pattern matched no code; bit i per digit i.
REQ-009 out_valid  output  1  SHALL indicate out_digits/out_bad hold a complete frame.
REQ-010 out_ready  input  1  SHALL indicate the consumer accepts the frame this cycle.
REQ-011 overrun  output  1  SHALL be a sticky flag set when a completed frame is dropped.

Function
REQ-012 Decode table SHALL be: 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_0000, A=000_1000, b=000_0011, C=100_0110, d=010_0001, E=000_0110, F=000_1110.
REQ-013 Any other pattern, blank (111_1111) included, SHALL decode as nibble 0 with the bad bit set.
REQ-014 A select is valid only when exactly one an_in bit is 0; a none- or multi-select SHALL clear the stability counter and capture nothing.
REQ-015 The stability counter SHALL increment while {an_in, seg_in} equals its previous-cycle value under a valid select, and SHALL restart at 1 on any change.
REQ-016 Capture SHALL occur exactly once, in the cycle the counter reaches STABLE_CYCLES; the counter then saturates, with no further capture until the pair changes.
REQ-017 Capture SHALL write the nibble and bad bit into slot i and set captured-mask bit i; recapture of the same slot before frame completion SHALL overwrite it.
REQ-018 FSM states: COLLECT, HOLD.
REQ-019 COLLECT -> HOLD: the cycle after the fourth mask bit is set, the frame SHALL load into the outputs, out_valid SHALL go 1, and the mask SHALL clear.
REQ-020 HOLD -> COLLECT: on out_valid & out_ready, out_valid SHALL be 0 the next cycle unless a new frame completes in that same cycle.
REQ-021 If a new frame completes in the same cycle as the accept, the new frame SHALL load and out_valid SHALL remain 1.
REQ-022 In HOLD, outputs SHALL be stable and capture SHALL continue into the internal slots.
REQ-023 If a frame completes in HOLD without a same-cycle accept, it SHALL be discarded, overrun SHALL be set, and the mask SHALL clear.
REQ-024 Minimum latency SHALL be STABLE_CYCLES cycles from the first stable cycle of the last digit to its capture, plus 1 cycle to out_valid.

Reset
REQ-025 While rst_n=0 at a clock edge, the following SHALL clear to 0: out_digits, out_bad, out_valid, overrun, mask, slots, stability counter and previous-value registers; the FSM SHALL enter COLLECT.
REQ-026 Reset mid-frame or in HOLD SHALL discard all partial and held data without asserting out_valid.

Structure
REQ-027 Package seg7_pkg SHALL hold the 16-entry code table, the SEG_BLANK constant, the DIGITS default and the FSM state enum.
REQ-028 Sub-module seg7_decode SHALL be purely combinational (7-bit pattern -> 4-bit nibble + bad) and instantiated once on seg_in.

Verification
REQ-029 Scan 1,2,3,4 on digits 0..3, each held 6 cycles, out_ready=1 -> out_valid pulses once; out_digits=16'h4321; out_bad=0.
REQ-030 Digit 2 held only 3 cycles (STABLE_CYCLES=4), then digits 0,1,3 scanned -> no out_valid until digit 2 is rescanned for 4 cycles.
REQ-031 Pattern 111_1111 on digit 1 in a full frame -> out_bad=4'b0010; digit 1 reads 0.
REQ-032 an_in=4'b0011 for 10 cycles -> no capture and mask unchanged.
REQ-033 out_ready=0 over two complete frames -> first frame held unchanged, overrun=1; out_ready=1 -> out_valid drops next cycle.
REQ-034 rst_n=0 for 1 cycle after 3 digits are captured -> all outputs 0; the next complete frame reports only post-reset captures.
